// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter feeding a shared 4-bit 4:1 mux into a one-entry valid/ready output stage.
// Optional per-requester saturating grant counters are enabled with `define RR_ARB_GRANT_CNT_EN.

module mux_4_1 (
  input  logic [1:0] sel,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  output logic [3:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end
endmodule

module rr_mux4_arbiter #(
  parameter int unsigned INIT_PTR = 0
`ifdef RR_ARB_GRANT_CNT_EN
  , parameter int unsigned CNT_W = 8
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req_valid,
  input  logic [3:0]           req_data0,
  input  logic [3:0]           req_data1,
  input  logic [3:0]           req_data2,
  input  logic [3:0]           req_data3,
  output logic [3:0]           req_ready,
  output logic                 out_valid,
  output logic [3:0]           out_data,
  output logic [1:0]           out_src,
  input  logic                 out_ready
`ifdef RR_ARB_GRANT_CNT_EN
  , output logic [4*CNT_W-1:0] grant_cnt
`endif
);

  localparam logic [1:0] PTR_RST = 2'(INIT_PTR);

  logic       out_valid_q, out_valid_d;
  logic [3:0] out_data_q, out_data_d;
  logic [1:0] out_src_q, out_src_d;
  logic [1:0] ptr_q, ptr_d;

  logic       load;
  logic       take;
  logic [7:0] req_dbl;
  logic [3:0] req_rot;
  logic [1:0] off;
  logic [1:0] grant;
  logic [3:0] mux_y;

  assign load = !out_valid_q || out_ready;
  assign take = rst_n && load && (|req_valid);

  // Rotate requests so the current top-priority requester sits at bit 0.
  assign req_dbl = {req_valid, req_valid} >> ptr_q;
  assign req_rot = req_dbl[3:0];

  always_comb begin
    off = 2'd0;
    casez (req_rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign grant     = ptr_q + off;
  assign req_ready = take ? (4'b0001 << grant) : 4'b0000;

  mux_4_1 u_mux (
    .sel (grant),
    .d0  (req_data0),
    .d1  (req_data1),
    .d2  (req_data2),
    .d3  (req_data3),
    .y   (mux_y)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load) begin
      out_valid_d = |req_valid;
      if (|req_valid) begin
        out_data_d = mux_y;
        out_src_d  = grant;
        ptr_d      = grant + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= 4'h0;
      out_src_q   <= 2'd0;
      ptr_q       <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

`ifdef RR_ARB_GRANT_CNT_EN
  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;

    // Saturate instead of wrapping so a long-running count never reads as small.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (req_ready[gi] && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed bench for rr_mux4_arbiter: a per-cycle reference model plus literal checkpoints.
// Grant-counter checks are included when RR_ARB_GRANT_CNT_EN is defined.

module tb_rr_mux4_arbiter;

`ifdef RR_ARB_GRANT_CNT_EN
  localparam int CNT_W = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_valid = 4'b0;
  logic [3:0] req_data0 = 4'h0;
  logic [3:0] req_data1 = 4'h0;
  logic [3:0] req_data2 = 4'h0;
  logic [3:0] req_data3 = 4'h0;
  logic [3:0] req_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic [1:0] out_src;
  logic       out_ready = 1'b0;
`ifdef RR_ARB_GRANT_CNT_EN
  logic [4*CNT_W-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

`ifdef RR_ARB_GRANT_CNT_EN
  rr_mux4_arbiter #(.INIT_PTR(0), .CNT_W(CNT_W)) dut (
`else
  rr_mux4_arbiter #(.INIT_PTR(0)) dut (
`endif
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data0 (req_data0),
    .req_data1 (req_data1),
    .req_data2 (req_data2),
    .req_data3 (req_data3),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
`ifdef RR_ARB_GRANT_CNT_EN
    , .grant_cnt (grant_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: state of the output stage and the priority pointer.
  logic       m_valid;
  logic [3:0] m_data;
  logic [1:0] m_src;
  int         m_ptr;
  int         m_cnt [4];

  function automatic int pick(input int ptr, input logic [3:0] v);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] word_of(input int g);
    case (g)
      0: return req_data0;
      1: return req_data1;
      2: return req_data2;
      default: return req_data3;
    endcase
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (!rst_n) return 4'b0;
    if (m_valid && !out_ready) return 4'b0;
    g = pick(m_ptr, req_valid);
    if (g < 0) return 4'b0;
    return 4'(1 << g);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int g;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 4'h0;
      m_src   <= 2'd0;
      m_ptr   <= 0;
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
    end else if (!m_valid || out_ready) begin
      g = pick(m_ptr, req_valid);
      if (g >= 0) begin
        m_valid <= 1'b1;
        m_data  <= word_of(g);
        m_src   <= 2'(g);
        m_ptr   <= (g + 1) % 4;
`ifdef RR_ARB_GRANT_CNT_EN
        if (m_cnt[g] < (1 << CNT_W) - 1) m_cnt[g] <= m_cnt[g] + 1;
`endif
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    check("model_req_ready", req_ready, exp_ready());
    check("model_out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("model_out_data", out_data, m_data);
      check("model_out_src", out_src, m_src);
    end
`ifdef RR_ARB_GRANT_CNT_EN
    for (int i = 0; i < 4; i++)
      check("model_grant_cnt", grant_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  logic [1:0] exp_seq [6];

  initial begin
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2;
    exp_seq[3] = 2'd3; exp_seq[4] = 2'd0; exp_seq[5] = 2'd1;

    // Reset state, with a request pending to confirm ready stays low
    req_valid = 4'b0100;
    req_data2 = 4'hA;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 4'h0);
    check("rst_out_src", out_src, 2'd0);
    check("rst_req_ready", req_ready, 4'b0000);

    // Single requester 2
    rst_n = 1'b1;
    #1;
    check("t1_req_ready", req_ready, 4'b0100);
    tick();
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_data", out_data, 4'hA);
    check("t1_out_src", out_src, 2'd2);
    req_valid = 4'b0000;
    tick();
    check("t1_drain_valid", out_valid, 1'b0);

    // Full rotation from INIT_PTR
    pulse_reset();
    req_data0 = 4'h1; req_data1 = 4'h2; req_data2 = 4'h3; req_data3 = 4'h4;
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("t2_out_src_seq", out_src, exp_seq[i]);
    end

    // Back-pressure holds everything; ptr is 2 here
    req_valid = 4'b0011;
    tick();
    check("t3_first_src", out_src, 2'd0);
    out_ready = 1'b0;
    #1;
    check("t3_stall_ready", req_ready, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_stall_src", out_src, 2'd0);
      check("t3_stall_data", out_data, 4'h1);
      check("t3_stall_ready_hold", req_ready, 4'b0000);
    end
    out_ready = 1'b1;
    tick();
    check("t3_resume_src", out_src, 2'd1);

    // Wrap-around fairness between 0 and 3
    req_valid = 4'b1000;
    tick();
    check("t4_src3", out_src, 2'd3);
    req_valid = 4'b1001;
    tick();
    check("t4_then0", out_src, 2'd0);
    tick();
    check("t4_then3", out_src, 2'd3);

    // Asynchronous reset while holding a word
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", out_valid, 1'b0);
    check("t5_async_data", out_data, 4'h0);
    check("t5_async_ready", req_ready, 4'b0000);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    req_valid = 4'b1111;
    tick();
    check("t5_restart_src0", out_src, 2'd0);
    tick();
    check("t5_restart_src1", out_src, 2'd1);

`ifdef RR_ARB_GRANT_CNT_EN
    // Counter saturation with CNT_W=2
    pulse_reset();
    req_valid = 4'b0010;
    for (int i = 0; i < 5; i++) tick();
    check("t6_grant_cnt", grant_cnt, 8'b0000_1100);
`endif

    req_valid = 4'b0000;
    tick();
    tick();
    check("end_idle_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
